fetch_redirect_ctrl: RTL and testbench

- Sequences the program counter and the IF/ID and ID/EX pipeline registers in the five-stage core.
- Arbitrates the EX-stage redirect requests (jalr, jal, taken branch) into a single redirect to the PC, and produces pc_write, flush and stall controls.
- Holds a redirect pending while instruction memory is busy.
- Sits between the hazard logic, the EX stage, instruction memory and the PC register.

---
 rtl/fetch_redirect_ctrl_pkg.sv | 33 +++
 rtl/fetch_redirect_ctrl_if.sv | 46 ++++
 rtl/fetch_redirect_ctrl_redirect_arbiter.sv | 37 +++
 rtl/fetch_redirect_ctrl.sv | 147 ++++++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types and constants for the fetch redirect controller.
//   fetch_state_t  : controller state encoding
//   XLEN           : address width of PC / redirect targets
//   REDIR_*        : redirect-source encoding, listed in priority order
package fetch_redirect_ctrl_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    RUN           = 2'd0,
    WAIT_MEM      = 2'd1,
    HOLD_REDIRECT = 2'd2
  } fetch_state_t;

  typedef logic [1:0] redir_src_t;

  localparam redir_src_t REDIR_NONE = 2'd0;
  localparam redir_src_t REDIR_JALR = 2'd1;
  localparam redir_src_t REDIR_JAL  = 2'd2;
  localparam redir_src_t REDIR_BR   = 2'd3;

  // Priority select: jalr > jal > taken branch.
  function automatic redir_src_t redir_select(input logic jalr, input logic jal,
                                              input logic br);
    redir_src_t src;
    src = REDIR_NONE;
    if (jalr)     src = REDIR_JALR;
    else if (jal) src = REDIR_JAL;
    else if (br)  src = REDIR_BR;
    return src;
  endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Bundle of the fetch controller's handshake and pipeline-control signals.
//   master : controller side (drives o_*, samples i_*)
//   slave  : environment side (hazard unit, EX stage, imem, PC/pipeline regs)
// Signal names are from the controller's point of view.
interface fetch_redirect_ctrl_if #(
  parameter int COUNT_W = 16
);
  import fetch_redirect_ctrl_pkg::*;

  logic               o_imem_req;
  logic               i_imem_ready;
  logic               i_load_use_hazard;
  logic               i_ex_jalr;
  logic               i_ex_jal;
  logic               i_ex_branch_taken;
  logic [XLEN-1:0]    i_ex_jalr_target;
  logic [XLEN-1:0]    i_ex_jal_target;
  logic [XLEN-1:0]    i_ex_branch_target;
  logic               o_pc_write;
  logic               o_redirect_valid;
  logic [XLEN-1:0]    o_redirect_target;
  logic               o_if_id_write;
  logic               o_flush_if_id;
  logic               o_flush_id_ex;
  logic               o_fetch_timeout;
  logic [COUNT_W-1:0] o_redirect_count;

  modport master (
    input  i_imem_ready, i_load_use_hazard,
    input  i_ex_jalr, i_ex_jal, i_ex_branch_taken,
    input  i_ex_jalr_target, i_ex_jal_target, i_ex_branch_target,
    output o_imem_req, o_pc_write, o_redirect_valid, o_redirect_target,
    output o_if_id_write, o_flush_if_id, o_flush_id_ex,
    output o_fetch_timeout, o_redirect_count
  );

  modport slave (
    output i_imem_ready, i_load_use_hazard,
    output i_ex_jalr, i_ex_jal, i_ex_branch_taken,
    output i_ex_jalr_target, i_ex_jal_target, i_ex_branch_target,
    input  o_imem_req, o_pc_write, o_redirect_valid, o_redirect_target,
    input  o_if_id_write, o_flush_if_id, o_flush_id_ex,
    input  o_fetch_timeout, o_redirect_count
  );

endinterface

// File: rtl/fetch_redirect_ctrl_redirect_arbiter.sv
// Combinational priority select of the three EX-stage redirect requests.
//   i_jalr/i_jal/i_br           : request flags
//   i_jalr_tgt/i_jal_tgt/i_br_tgt : matching targets
//   o_valid  : any request present
//   o_target : target of the winning request (0 when none)
//   o_src    : winning source (REDIR_*)
module redirect_arbiter
  import fetch_redirect_ctrl_pkg::*;
(
  input  logic            i_jalr,
  input  logic            i_jal,
  input  logic            i_br,
  input  logic [XLEN-1:0] i_jalr_tgt,
  input  logic [XLEN-1:0] i_jal_tgt,
  input  logic [XLEN-1:0] i_br_tgt,
  output logic            o_valid,
  output logic [XLEN-1:0] o_target,
  output redir_src_t      o_src
);

  redir_src_t w_src;

  always_comb begin
    w_src    = redir_select(i_jalr, i_jal, i_br);
    o_target = '0;
    case (w_src)
      REDIR_JALR: o_target = i_jalr_tgt;
      REDIR_JAL:  o_target = i_jal_tgt;
      REDIR_BR:   o_target = i_br_tgt;
      default:    o_target = '0;
    endcase
  end

  assign o_valid = (w_src != REDIR_NONE);
  assign o_src   = w_src;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: sequences PC and IF/ID, ID/EX pipeline registers,
// merges EX redirects into one PC redirect and holds it while imem is busy.
//   i_clk, i_reset : clock, synchronous active-high reset
//   bus (master)   : imem handshake, hazard/EX inputs, PC and pipeline controls,
//                    sticky fetch timeout and saturating redirect counter
//
// state         | meaning
// --------------+-------------------------------------------------------
// RUN           | normal fetch, last imem access completed
// WAIT_MEM      | imem busy, fetch stalled and IF/ID bubbled
// HOLD_REDIRECT | redirect accepted while imem busy; replay pending target
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int COUNT_W  = 16,
  parameter int MAX_WAIT = 64
) (
  input logic                  i_clk,
  input logic                  i_reset,
  fetch_redirect_ctrl_if.master bus
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  fetch_state_t       r_state;
  logic [XLEN-1:0]    r_pending_target;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic               r_fetch_timeout;
  logic [COUNT_W-1:0] r_redirect_count;

  logic               w_ex_valid;
  logic [XLEN-1:0]    w_ex_target;
  redir_src_t         w_ex_src;
  logic [WAIT_W-1:0]  w_wait_inc;
  logic [COUNT_W-1:0] w_count_inc;

  redirect_arbiter u_arb (
    .i_jalr     (bus.i_ex_jalr),
    .i_jal      (bus.i_ex_jal),
    .i_br       (bus.i_ex_branch_taken),
    .i_jalr_tgt (bus.i_ex_jalr_target),
    .i_jal_tgt  (bus.i_ex_jal_target),
    .i_br_tgt   (bus.i_ex_branch_target),
    .o_valid    (w_ex_valid),
    .o_target   (w_ex_target),
    .o_src      (w_ex_src)
  );

  assign w_wait_inc  = (r_wait_cnt == WAIT_LIMIT) ? r_wait_cnt : r_wait_cnt + 1'b1;
  assign w_count_inc = (&r_redirect_count) ? r_redirect_count : r_redirect_count + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state          <= RUN;
      r_pending_target <= '0;
      r_wait_cnt       <= '0;
      r_fetch_timeout  <= 1'b0;
      r_redirect_count <= '0;
    end else begin
      case (r_state)
        RUN, WAIT_MEM: begin
          if (w_ex_valid) begin
            r_redirect_count <= w_count_inc;
            if (bus.i_imem_ready) begin
              r_state <= RUN;
            end else begin
              r_pending_target <= w_ex_target;
              r_state          <= HOLD_REDIRECT;
            end
          end else if (bus.i_load_use_hazard) begin
            // stall: state and wait counter frozen
            r_state <= r_state;
          end else if (bus.i_imem_ready) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
          end else begin
            r_state    <= WAIT_MEM;
            r_wait_cnt <= w_wait_inc;
            if (w_wait_inc == WAIT_LIMIT) r_fetch_timeout <= 1'b1;
          end
        end
        HOLD_REDIRECT: begin
          if (bus.i_imem_ready) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= w_wait_inc;
            if (w_wait_inc == WAIT_LIMIT) r_fetch_timeout <= 1'b1;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  logic            w_imem_req;
  logic            w_pc_write;
  logic            w_redirect_valid;
  logic [XLEN-1:0] w_redirect_target;
  logic            w_if_id_write;
  logic            w_flush_if_id;
  logic            w_flush_id_ex;

  always_comb begin
    w_imem_req        = 1'b0;
    w_pc_write        = 1'b0;
    w_redirect_valid  = 1'b0;
    w_redirect_target = '0;
    w_if_id_write     = 1'b0;
    w_flush_if_id     = 1'b1;
    w_flush_id_ex     = 1'b1;
    if (!i_reset) begin
      w_imem_req = 1'b1;
      if (r_state == HOLD_REDIRECT) begin
        // EX holds a bubble here, so its redirect inputs and the hazard are moot
        w_redirect_valid  = 1'b1;
        w_redirect_target = r_pending_target;
        w_pc_write        = bus.i_imem_ready;
      end else if (w_ex_valid) begin
        w_redirect_valid  = 1'b1;
        w_redirect_target = w_ex_target;
        w_pc_write        = bus.i_imem_ready;
      end else if (bus.i_load_use_hazard) begin
        w_flush_if_id = 1'b0;
      end else if (bus.i_imem_ready) begin
        w_pc_write    = 1'b1;
        w_if_id_write = 1'b1;
        w_flush_if_id = 1'b0;
        w_flush_id_ex = 1'b0;
      end else begin
        w_flush_id_ex = 1'b0;
      end
    end
  end

  assign bus.o_imem_req        = w_imem_req;
  assign bus.o_pc_write        = w_pc_write;
  assign bus.o_redirect_valid  = w_redirect_valid;
  assign bus.o_redirect_target = w_redirect_target;
  assign bus.o_if_id_write     = w_if_id_write;
  assign bus.o_flush_if_id     = w_flush_if_id;
  assign bus.o_flush_id_ex     = w_flush_id_ex;
  assign bus.o_fetch_timeout   = r_fetch_timeout;
  assign bus.o_redirect_count  = r_redirect_count;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Self-checking bench for fetch_redirect_ctrl (COUNT_W=4, MAX_WAIT=4).
module tb_fetch_redirect_ctrl;
  localparam int CW    = 4;
  localparam int MAXW  = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_redirect_ctrl_if #(.COUNT_W(CW)) bus ();

  fetch_redirect_ctrl #(.COUNT_W(CW), .MAX_WAIT(MAXW)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: "holding" means a redirect is waiting for imem
  bit        m_hold;
  bit [31:0] m_pend;
  int        m_wait;
  bit        m_to;
  int        m_cnt;

  bit        e_req, e_pcw, e_rv, e_ifw, e_ifw_care, e_fif, e_fie, e_to;
  bit [31:0] e_rt;
  bit [CW-1:0] e_cnt;

  task automatic drive(input bit rdy, input bit haz, input bit jr, input bit j,
                       input bit br, input bit [31:0] tjr, input bit [31:0] tj,
                       input bit [31:0] tbr);
    bus.i_imem_ready       = rdy;
    bus.i_load_use_hazard  = haz;
    bus.i_ex_jalr          = jr;
    bus.i_ex_jal           = j;
    bus.i_ex_branch_taken  = br;
    bus.i_ex_jalr_target   = tjr;
    bus.i_ex_jal_target    = tj;
    bus.i_ex_branch_target = tbr;
  endtask

  function automatic bit [31:0] sel_target();
    if (bus.i_ex_jalr) return bus.i_ex_jalr_target;
    if (bus.i_ex_jal)  return bus.i_ex_jal_target;
    return bus.i_ex_branch_target;
  endfunction

  // expected outputs for the current inputs, then wait until mid-cycle
  task automatic eval();
    bit ex;
    ex = bus.i_ex_jalr | bus.i_ex_jal | bus.i_ex_branch_taken;
    e_req = 1; e_pcw = 0; e_rv = 0; e_rt = 0; e_ifw = 0; e_ifw_care = 1;
    e_fif = 1; e_fie = 1;
    e_to  = m_to;
    e_cnt = CW'(m_cnt);
    if (rst) begin
      e_req = 0;
    end else if (m_hold) begin
      e_rv = 1; e_rt = m_pend; e_pcw = bus.i_imem_ready;
    end else if (ex) begin
      e_rv = 1; e_rt = sel_target(); e_pcw = bus.i_imem_ready; e_ifw_care = 0;
    end else if (bus.i_load_use_hazard) begin
      e_fif = 0;
    end else if (bus.i_imem_ready) begin
      e_pcw = 1; e_ifw = 1; e_fif = 0; e_fie = 0;
    end else begin
      e_fie = 0;
    end
    @(negedge clk);
  endtask

  task automatic wait_tick();
    if (m_wait < MAXW) m_wait++;
    if (m_wait == MAXW) m_to = 1;
  endtask

  // advance the model by one clock and move to just after the next edge
  task automatic commit();
    bit ex;
    ex = bus.i_ex_jalr | bus.i_ex_jal | bus.i_ex_branch_taken;
    if (rst) begin
      m_hold = 0; m_pend = 0; m_wait = 0; m_to = 0; m_cnt = 0;
    end else if (m_hold) begin
      if (bus.i_imem_ready) begin m_hold = 0; m_wait = 0; end
      else wait_tick();
    end else if (ex) begin
      if (m_cnt < CMAX) m_cnt++;
      if (!bus.i_imem_ready) begin m_hold = 1; m_pend = sel_target(); end
    end else if (bus.i_load_use_hazard) begin
    end else if (bus.i_imem_ready) begin
      m_wait = 0;
    end else begin
      wait_tick();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    eval();
    commit();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    drive(1, 1, 1, 1, 1, 32'h10, 32'h20, 32'h30);
    eval();
    n_cmp++;
    if ({bus.o_imem_req, bus.o_pc_write, bus.o_if_id_write, bus.o_redirect_valid,
         bus.o_flush_if_id, bus.o_flush_id_ex} !== 6'b000011 || bus.o_redirect_target !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got req=%b pcw=%b ifw=%b rv=%b fif=%b fie=%b rt=%h, exp 0 0 0 0 1 1 0",
               bus.o_imem_req, bus.o_pc_write, bus.o_if_id_write, bus.o_redirect_valid,
               bus.o_flush_if_id, bus.o_flush_id_ex, bus.o_redirect_target);
    end
    commit();
    rst = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    eval();
    n_cmp++;
    if (bus.o_fetch_timeout !== 1'b0 || bus.o_redirect_count !== '0 || bus.o_imem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_flops: got to=%b cnt=%0d req=%b, exp 0 0 1",
               bus.o_fetch_timeout, bus.o_redirect_count, bus.o_imem_req);
    end
    commit();
  endtask

  task automatic test_sequential();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      eval();
      n_cmp++;
      if ({bus.o_pc_write, bus.o_if_id_write, bus.o_fetch_timeout} !== 3'b110 ||
          bus.o_redirect_count !== '0) begin
        n_bad++;
        $display("FAIL seq_fetch cyc %0d: got pcw=%b ifw=%b to=%b cnt=%0d, exp 1 1 0 0", c,
                 bus.o_pc_write, bus.o_if_id_write, bus.o_fetch_timeout, bus.o_redirect_count);
      end
      commit();
    end
  endtask

  task automatic test_priority();
    do_reset();
    drive(1, 0, 0, 1, 1, 32'h0, 32'h100, 32'h200);
    eval();
    n_cmp++;
    if ({bus.o_redirect_valid, bus.o_flush_if_id, bus.o_flush_id_ex, bus.o_pc_write} !== 4'b1111 ||
        bus.o_redirect_target !== 32'h100) begin
      n_bad++;
      $display("FAIL jal_over_branch: got rv=%b fif=%b fie=%b pcw=%b rt=%h, exp 1 1 1 1 00000100",
               bus.o_redirect_valid, bus.o_flush_if_id, bus.o_flush_id_ex, bus.o_pc_write,
               bus.o_redirect_target);
    end
    commit();
    drive(1, 0, 1, 1, 1, 32'h300, 32'h100, 32'h200);
    eval();
    n_cmp++;
    if (bus.o_redirect_count !== CW'(1) || bus.o_redirect_target !== 32'h300) begin
      n_bad++;
      $display("FAIL jalr_over_all: got cnt=%0d rt=%h, exp 1 00000300",
               bus.o_redirect_count, bus.o_redirect_target);
    end
    commit();
  endtask

  task automatic test_hold_redirect();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      if (c == 0)      drive(0, 0, 1, 0, 0, 32'h44, 0, 0);
      else if (c == 2) drive(0, 1, 0, 0, 1, 0, 0, 32'h999);
      else             drive(c == 3, 0, 0, 0, 0, 0, 0, 0);
      eval();
      n_cmp++;
      if (bus.o_redirect_valid !== 1'b1 || bus.o_redirect_target !== 32'h44 ||
          bus.o_pc_write !== (c == 3) || bus.o_flush_if_id !== 1'b1 || bus.o_flush_id_ex !== 1'b1 ||
          (c > 0 && bus.o_if_id_write !== 1'b0) || (c > 0 && bus.o_redirect_count !== CW'(1))) begin
        n_bad++;
        $display("FAIL hold_redirect cyc %0d: got rv=%b rt=%h pcw=%b fif=%b fie=%b ifw=%b cnt=%0d, exp rt=00000044 pcw=%b cnt=1",
                 c, bus.o_redirect_valid, bus.o_redirect_target, bus.o_pc_write, bus.o_flush_if_id,
                 bus.o_flush_id_ex, bus.o_if_id_write, bus.o_redirect_count, c == 3);
      end
      commit();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    eval();
    n_cmp++;
    if (bus.o_redirect_valid !== 1'b0 || bus.o_pc_write !== 1'b1 || bus.o_redirect_count !== CW'(1)) begin
      n_bad++;
      $display("FAIL hold_release: got rv=%b pcw=%b cnt=%0d, exp 0 1 1",
               bus.o_redirect_valid, bus.o_pc_write, bus.o_redirect_count);
    end
    commit();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    eval();
    n_cmp++;
    if ({bus.o_pc_write, bus.o_if_id_write, bus.o_flush_id_ex, bus.o_flush_if_id} !== 4'b0010) begin
      n_bad++;
      $display("FAIL load_use_stall: got pcw=%b ifw=%b fie=%b fif=%b, exp 0 0 1 0",
               bus.o_pc_write, bus.o_if_id_write, bus.o_flush_id_ex, bus.o_flush_if_id);
    end
    commit();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    eval();
    n_cmp++;
    if ({bus.o_pc_write, bus.o_if_id_write} !== 2'b11) begin
      n_bad++;
      $display("FAIL load_use_resume: got pcw=%b ifw=%b, exp 1 1", bus.o_pc_write, bus.o_if_id_write);
    end
    commit();
  endtask

  task automatic test_timeout();
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      eval();
      n_cmp++;
      if (bus.o_flush_if_id !== 1'b1 || bus.o_pc_write !== 1'b0 || bus.o_fetch_timeout !== (c >= 5)) begin
        n_bad++;
        $display("FAIL timeout cyc %0d: got fif=%b pcw=%b to=%b, exp 1 0 %b", c,
                 bus.o_flush_if_id, bus.o_pc_write, bus.o_fetch_timeout, c >= 5);
      end
      commit();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    eval();
    commit();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    eval();
    n_cmp++;
    if (bus.o_fetch_timeout !== 1'b1 || bus.o_pc_write !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_sticky: got to=%b pcw=%b, exp 1 1", bus.o_fetch_timeout, bus.o_pc_write);
    end
    commit();
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    drive(0, 0, 0, 1, 0, 0, 32'h80, 0);
    eval();
    commit();
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      eval();
      commit();
    end
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    eval();
    n_cmp++;
    if (bus.o_redirect_valid !== 1'b0 || bus.o_redirect_target !== 32'h0 ||
        bus.o_fetch_timeout !== 1'b0 || bus.o_redirect_count !== '0) begin
      n_bad++;
      $display("FAIL reset_in_hold: got rv=%b rt=%h to=%b cnt=%0d, exp 0 0 0 0",
               bus.o_redirect_valid, bus.o_redirect_target, bus.o_fetch_timeout, bus.o_redirect_count);
    end
    commit();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    eval();
    n_cmp++;
    if ({bus.o_pc_write, bus.o_if_id_write, bus.o_redirect_valid} !== 3'b110) begin
      n_bad++;
      $display("FAIL reset_in_hold_run: got pcw=%b ifw=%b rv=%b, exp 1 1 0",
               bus.o_pc_write, bus.o_if_id_write, bus.o_redirect_valid);
    end
    commit();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 9) < 6, $urandom_range(0, 4) == 0,
            $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0,
            $urandom, $urandom, $urandom);
      eval();
      n_cmp++;
      if ({bus.o_imem_req, bus.o_pc_write, bus.o_redirect_valid, bus.o_flush_if_id,
           bus.o_flush_id_ex, bus.o_fetch_timeout} !== {e_req, e_pcw, e_rv, e_fif, e_fie, e_to} ||
          bus.o_redirect_target !== e_rt || bus.o_redirect_count !== e_cnt ||
          (e_ifw_care && bus.o_if_id_write !== e_ifw)) begin
        n_bad++;
        $display("FAIL random cyc %0d: got req,pcw,rv,fif,fie,to=%b%b%b%b%b%b ifw=%b rt=%h cnt=%0d, exp %b%b%b%b%b%b ifw=%b rt=%h cnt=%0d",
                 i, bus.o_imem_req, bus.o_pc_write, bus.o_redirect_valid, bus.o_flush_if_id,
                 bus.o_flush_id_ex, bus.o_fetch_timeout, bus.o_if_id_write, bus.o_redirect_target,
                 bus.o_redirect_count, e_req, e_pcw, e_rv, e_fif, e_fie, e_to, e_ifw, e_rt, e_cnt);
      end
      commit();
    end
    rst = 0;
  endtask

  initial begin
    rst = 1;
    m_hold = 0; m_pend = 0; m_wait = 0; m_to = 0; m_cnt = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    test_reset();
    test_sequential();
    test_priority();
    test_hold_redirect();
    test_load_use();
    test_timeout();
    test_reset_in_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
